// File: rtl/instr_stream_encoder_pkg.sv
// rtl/instr_stream_encoder_pkg.sv - shared opcode constants and FSM state type
package instr_stream_encoder_pkg;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } enc_state_t;

endpackage

// File: rtl/instr_word_pack.sv
// rtl/instr_word_pack.sv - combinational field packer with immediate range check
module instr_word_pack
    import instr_stream_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        reject
);

    logic fits_12;
    logic fits_13;
    logic fits_21;

    // Immediate fits when every bit above the encodable sign bit matches it.
    assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        word   = '0;
        reject = 1'b1;
        case (opcode)
            OP_R: begin
                word   = {funct7, rs2, rs1, funct3, rd, opcode};
                reject = 1'b0;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                word   = {imm[11:0], rs1, funct3, rd, opcode};
                reject = ~fits_12;
            end
            OP_STORE: begin
                word   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                reject = ~fits_12;
            end
            OP_BRANCH: begin
                word   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                reject = ~fits_13 | imm[0];
            end
            OP_LUI, OP_AUIPC: begin
                word   = {imm[31:12], rd, opcode};
                reject = |imm[11:0];
            end
            OP_JAL: begin
                word   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                reject = ~fits_21 | imm[0];
            end
            default: begin
                word   = '0;
                reject = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// rtl/instr_stream_encoder.sv - job-driven instruction field to word stream encoder
module instr_stream_encoder
    import instr_stream_encoder_pkg::*;
#(
    parameter int LEN_W     = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_addr,
    output logic             err_pulse,
    output logic [LEN_W-1:0] err_count,
    output logic             busy,
    output logic             done
);

    enc_state_t       state;
    logic [31:0]      next_addr;
    logic [LEN_W-1:0] remaining;
    logic [31:0]      packed_word;
    logic             packed_reject;
    logic             accept;

    instr_word_pack u_pack (
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .word   (packed_word),
        .reject (packed_reject)
    );

    // Output slot is free when empty or being drained this cycle.
    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            next_addr <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            done      <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        next_addr <= base_addr;
                        remaining <= len;
                        err_count <= '0;
                        busy      <= 1'b1;
                        if (len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        remaining <= remaining - 1'b1;
                        if (packed_reject) begin
                            err_pulse <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + 1'b1;
                            end
                        end else begin
                            out_instr <= packed_word;
                            out_addr  <= next_addr;
                            out_valid <= 1'b1;
                            next_addr <= next_addr + 32'(ADDR_STEP);
                        end
                        if (remaining == LEN_W'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid || out_ready) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// tb/tb_instr_stream_encoder.sv - scoreboard bench for instr_stream_encoder
module tb_instr_stream_encoder;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      base_addr;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_opcode;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [31:0]      out_addr;
    logic             err_pulse;
    logic [LEN_W-1:0] err_count;
    logic             busy;
    logic             done;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp      = 0;
    int   n_fail     = 0;
    int   err_seen   = 0;
    int   done_seen  = 0;
    int   cyc        = 0;
    int   accept_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_stream_encoder #(.LEN_W(LEN_W), .ADDR_STEP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (err_pulse) err_seen++;
                if (done) done_seen++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_word: got 0x%08h at 0x%08h, expected none", out_instr, out_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_instr", out_instr, e.instr);
                        check("out_addr", out_addr, e.addr);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] addr);
        exp_q.push_back({instr, addr});
    endtask

    task automatic start_job(input logic [31:0] b, input logic [LEN_W-1:0] l);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        tick();
        start     = 1'b0;
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        int n;
        set_fields(op, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: got in_ready 0 for 50 cycles, expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        accept_cyc = cyc;
    endtask

    task automatic wait_done(input int total);
        int n;
        n = 0;
        while (done_seen < total && n < 200) begin
            tick();
            n++;
        end
        tick(2);
        check("done_count", done_seen, total);
    endtask

    initial begin
        int a2;
        int e0;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_fields(7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_addr", out_addr, 32'h0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_count", err_count, 0);
        check("rst_in_ready", in_ready, 0);
        tick();

        // Basic three-word job
        start_job(32'h100, 3);
        push(32'h00500093, 32'h100);
        push(32'h002081B3, 32'h104);
        push(32'h0020A423, 32'h108);
        send(7'h13, 5'd1, 5'd0, 5'd7, 3'd0, 7'h55, 32'd5);
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF);
        send(7'h23, 5'h1F, 5'd1, 5'd2, 3'd2, 7'h7F, 32'd8);
        in_valid = 1'b0;
        wait_done(1);
        check("busy_after_done", busy, 0);

        // Branch, jump and upper-immediate encodings
        start_job(32'h1000, 3);
        push(32'hFE208EE3, 32'h1000);
        push(32'h001000EF, 32'h1004);
        push(32'h123452B7, 32'h1008);
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC);
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800);
        send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000);
        in_valid = 1'b0;
        wait_done(2);

        // Rejected entries consume slots but not addresses
        e0 = err_seen;
        start_job(32'h200, 5);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800);
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000003);
        send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001);
        send(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h0);
        in_valid = 1'b0;
        tick(2);
        check("err_pulses", err_seen - e0, 4);
        check("err_count", err_count, 4);
        check("err_no_out_valid", out_valid, 0);
        push(32'h00500093, 32'h200);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5);
        in_valid = 1'b0;
        wait_done(3);
        check("err_count_hold", err_count, 4);

        // Backpressure then full throughput
        start_job(32'h300, 4);
        out_ready = 1'b0;
        push(32'h00100093, 32'h300);
        push(32'h00200093, 32'h304);
        push(32'h00300093, 32'h308);
        push(32'h00400093, 32'h30C);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
        set_fields(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_instr", out_instr, 32'h00100093);
            check("stall_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2);
        a2 = accept_cyc;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4);
        in_valid = 1'b0;
        check("throughput_cycles", accept_cyc - a2, 2);
        wait_done(4);

        // Zero-length job completes immediately
        start_job(32'h400, 0);
        @(negedge clk);
        check("len0_done", done, 1);
        check("len0_busy", busy, 1);
        check("len0_out_valid", out_valid, 0);
        @(negedge clk);
        check("len0_done_drop", done, 0);
        check("len0_busy_drop", busy, 0);
        tick();
        check("len0_done_count", done_seen, 5);

        // Start while running is ignored
        start_job(32'h500, 2);
        push(32'h00100093, 32'h500);
        push(32'h00200093, 32'h504);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
        in_valid = 1'b0;
        start_job(32'h900, 7);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2);
        in_valid = 1'b0;
        wait_done(6);

        // Reset mid-job drops the pending word
        start_job(32'h600, 3);
        out_ready = 1'b0;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd9);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_out_valid", out_valid, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_reset_out_valid", out_valid, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_in_ready", in_ready, 0);
        tick(3);
        check("mid_reset_no_done", done_seen, 6);
        out_ready = 1'b1;

        // Address wrap
        start_job(32'hFFFFFFFC, 2);
        push(32'h00100093, 32'hFFFFFFFC);
        push(32'h00200093, 32'h00000000);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2);
        in_valid = 1'b0;
        wait_done(7);

        tick(3);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
